// File: rtl/burst_master.sv
// Burst initiator: accepts one request, then issues BURST_LEN single-beat SRAM
// accesses at incrementing addresses, with a streamed write path and a latency-matched read return.
module burst_master #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  rdata_valid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  done,
    output logic                  mem_burst_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wren,
    output logic                  mem_rden,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    localparam int              CW        = $clog2(BURST_LEN + 1);
    localparam logic [CW-1:0]   LAST_BEAT = CW'(BURST_LEN - 1);
    localparam logic [CW-1:0]   FULL_CNT  = CW'(BURST_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [CW-1:0]         r_beat;
    logic [CW-1:0]         r_ret_cnt;
    logic [RD_LATENCY-1:0] r_rd_pipe;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rdata_valid;
    logic                  r_done;

    logic                  w_active;
    logic                  w_wr_xfer;
    logic                  w_rd_ret;
    logic                  w_accept;

    assign w_active  = (r_state == S_WRITE) || (r_state == S_READ);
    assign w_wr_xfer = (r_state == S_WRITE) && wdata_valid;
    assign w_rd_ret  = r_rd_pipe[RD_LATENCY-1];
    assign w_accept  = (r_state == S_IDLE) && req_valid;

    // Write beats pass straight through to the SRAM; data is gated so the bus is quiet outside WRITE.
    assign req_ready    = (r_state == S_IDLE);
    assign wdata_ready  = w_wr_xfer;
    assign mem_burst_en = w_active;
    assign mem_addr     = w_active ? (r_base + ADDR_WIDTH'(r_beat)) : '0;
    assign mem_wren     = w_wr_xfer;
    assign mem_wr_data  = (r_state == S_WRITE) ? wdata : '0;
    assign mem_rden     = (r_state == S_READ);
    assign rdata_valid  = r_rdata_valid;
    assign rdata        = r_rdata;
    assign done         = r_done;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_base  <= '0;
            r_beat  <= '0;
            r_done  <= 1'b0;
        end else begin
            // NOTE: registered state uses non-blocking assignments; the default below makes done a one-cycle pulse.
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_base  <= req_addr;
                        r_beat  <= '0;
                        r_state <= req_write ? S_WRITE : S_READ;
                    end
                end
                S_WRITE: begin
                    if (wdata_valid) begin
                        if (r_beat != FULL_CNT) r_beat <= r_beat + CW'(1);
                        if (r_beat == LAST_BEAT) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (r_beat != FULL_CNT) r_beat <= r_beat + CW'(1);
                    if (r_beat == LAST_BEAT) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    // done rises together with the final returned beat; leave DRAIN one cycle later.
                    if (w_rd_ret && (r_ret_cnt == LAST_BEAT)) r_done <= 1'b1;
                    if (r_done) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_pipe     <= '0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_ret_cnt     <= '0;
        end else begin
            r_rd_pipe[0] <= (r_state == S_READ);
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_rd_pipe[i] <= r_rd_pipe[i-1];
            end
            r_rdata_valid <= w_rd_ret;
            if (w_rd_ret) begin
                r_rdata <= mem_rd_data;
                if (r_ret_cnt != FULL_CNT) r_ret_cnt <= r_ret_cnt + CW'(1);
            end
            if (w_accept) r_ret_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_burst_master.sv
// Directed bench for burst_master (BURST_LEN=8, RD_LATENCY=1) with a simple SRAM model.
module tb_burst_master;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic        wdata_valid;
    logic        wdata_ready;
    logic [7:0]  wdata;
    logic        rdata_valid;
    logic [7:0]  rdata;
    logic        done;
    logic        mem_burst_en;
    logic [15:0] mem_addr;
    logic        mem_wren;
    logic        mem_rden;
    logic [7:0]  mem_wr_data;
    logic [7:0]  mem_rd_data;

    int n_checks = 0;
    int n_fail   = 0;

    burst_master #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(8),
        .BURST_LEN (8),
        .RD_LATENCY(1)
    ) u_dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .wdata       (wdata),
        .rdata_valid (rdata_valid),
        .rdata       (rdata),
        .done        (done),
        .mem_burst_en(mem_burst_en),
        .mem_addr    (mem_addr),
        .mem_wren    (mem_wren),
        .mem_rden    (mem_rden),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model with one cycle of read latency.
    logic [7:0] mem [0:65535];
    logic [7:0] rd_q = 8'h00;
    always @(posedge clk) begin
        if (mem_wren) mem[mem_addr] <= mem_wr_data;
        if (mem_rden) rd_q <= mem[mem_addr];
    end
    assign mem_rd_data = rd_q;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " req_ready"},   req_ready,    1);
        check({tag, " wdata_ready"}, wdata_ready,  0);
        check({tag, " rdata_valid"}, rdata_valid,  0);
        check({tag, " rdata"},       rdata,        0);
        check({tag, " done"},        done,         0);
        check({tag, " burst_en"},    mem_burst_en, 0);
        check({tag, " mem_addr"},    mem_addr,     0);
        check({tag, " mem_wren"},    mem_wren,     0);
        check({tag, " mem_rden"},    mem_rden,     0);
        check({tag, " mem_wr_data"}, mem_wr_data,  0);
    endtask

    typedef struct {
        logic        rv;
        logic        rw;
        logic [15:0] ra;
        logic        wv;
        logic [7:0]  wd;
        logic        e_rr;
        logic        e_wrdy;
        logic        e_wren;
        logic        e_ben;
        logic [15:0] e_addr;
        logic        e_done;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(input logic rv, input logic rw, input logic [15:0] ra,
                                    input logic wv, input logic [7:0] wd,
                                    input logic e_rr, input logic e_wrdy, input logic e_wren,
                                    input logic e_ben, input logic [15:0] e_addr, input logic e_done);
        vec_t v;
        v.rv = rv; v.rw = rw; v.ra = ra; v.wv = wv; v.wd = wd;
        v.e_rr = e_rr; v.e_wrdy = e_wrdy; v.e_wren = e_wren;
        v.e_ben = e_ben; v.e_addr = e_addr; v.e_done = e_done;
        vecs.push_back(v);
    endfunction

    // One write burst: accept cycle, beats (with a stall cycle before each beat flagged in stall),
    // the done cycle, then an IDLE cycle presenting a stray write beat that must be ignored.
    function automatic void add_write(input logic [15:0] base, input logic [7:0] d0, input logic [7:0] stall);
        add_vec(1, 1, base, 0, 8'h00, 1, 0, 0, 0, 16'h0000, 0);
        for (int i = 0; i < 8; i++) begin
            if (stall[i]) add_vec(0, 0, 16'h0000, 0, 8'hEE, 0, 0, 0, 1, 16'(base + i), 0);
            add_vec(0, 0, 16'h0000, 1, 8'(d0 + i), 0, 1, 1, 1, 16'(base + i), 0);
        end
        add_vec(0, 0, 16'h0000, 0, 8'h00, 1, 0, 0, 0, 16'h0000, 1);
        add_vec(0, 0, 16'h0000, 1, 8'h77, 1, 0, 0, 0, 16'h0000, 0);
    endfunction

    // Read burst of 8 from base expecting data d0, d0+1, ...; optionally pokes a second request mid-burst.
    task automatic read_burst(input logic [15:0] base, input logic [7:0] d0, input bit poke);
        logic        exp_rden;
        logic        exp_rv;
        logic [15:0] ea;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            req_valid = (k == 0) || (poke && k == 4);
            req_write = (poke && k == 4);
            req_addr  = (poke && k == 4) ? 16'h2000 : base;
            #1;
            exp_rden = (k >= 1) && (k <= 8);
            exp_rv   = (k >= 3) && (k <= 10);
            ea       = base + 16'(k - 1);
            check($sformatf("rd %0h k%0d req_ready", base, k), req_ready, (k == 0 || k >= 11));
            check($sformatf("rd %0h k%0d mem_rden", base, k), mem_rden, exp_rden);
            check($sformatf("rd %0h k%0d burst_en", base, k), mem_burst_en, exp_rden);
            check($sformatf("rd %0h k%0d mem_wren", base, k), mem_wren, 0);
            if (exp_rden) check($sformatf("rd %0h k%0d mem_addr", base, k), mem_addr, ea);
            check($sformatf("rd %0h k%0d rdata_valid", base, k), rdata_valid, exp_rv);
            if (exp_rv) check($sformatf("rd %0h k%0d rdata", base, k), rdata, 8'(d0 + k - 3));
            check($sformatf("rd %0h k%0d done", base, k), done, (k == 10));
        end
        req_valid = 1'b0;
    endtask

    initial begin
        rstn        = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = 16'h1234;
        wdata_valid = 1'b1;
        wdata       = 8'h5A;

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_quiet("reset");

        @(negedge clk);
        rstn        = 1'b1;
        wdata_valid = 1'b0;
        wdata       = 8'h00;

        add_write(16'h0100, 8'hA0, 8'b0000_0000);
        add_write(16'h0200, 8'hB0, 8'b0010_0100);
        add_write(16'hFFFE, 8'hC0, 8'b0000_0000);

        for (int n = 0; n < vecs.size(); n++) begin
            vec_t v;
            v = vecs[n];
            @(negedge clk);
            req_valid   = v.rv;
            req_write   = v.rw;
            req_addr    = v.ra;
            wdata_valid = v.wv;
            wdata       = v.wd;
            #1;
            check($sformatf("vec%0d req_ready", n),   req_ready,    v.e_rr);
            check($sformatf("vec%0d wdata_ready", n), wdata_ready,  v.e_wrdy);
            check($sformatf("vec%0d mem_wren", n),    mem_wren,     v.e_wren);
            check($sformatf("vec%0d burst_en", n),    mem_burst_en, v.e_ben);
            check($sformatf("vec%0d mem_rden", n),    mem_rden,     0);
            check($sformatf("vec%0d done", n),        done,         v.e_done);
            if (v.e_ben) check($sformatf("vec%0d mem_addr", n), mem_addr, v.e_addr);
            if (v.e_wren) check($sformatf("vec%0d mem_wr_data", n), mem_wr_data, v.wd);
        end
        @(negedge clk);
        wdata_valid = 1'b0;
        wdata       = 8'h00;

        for (int i = 0; i < 8; i++) begin
            check($sformatf("mem 0100+%0d", i), mem[16'h0100 + 16'(i)], 8'(8'hA0 + i));
            check($sformatf("mem 0200+%0d", i), mem[16'h0200 + 16'(i)], 8'(8'hB0 + i));
            check($sformatf("mem FFFE+%0d", i), mem[16'hFFFE + 16'(i)], 8'(8'hC0 + i));
        end

        read_burst(16'h0100, 8'hA0, 1'b1);
        read_burst(16'h0200, 8'hB0, 1'b0);
        read_burst(16'hFFFE, 8'hC0, 1'b0);

        // Abandon a read after beat 3 has been issued.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'h0100;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        #1;
        check("midrd beat3 addr", mem_addr, 16'h0103);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check_quiet("midrd reset");
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("post-reset k%0d rdata_valid", k), rdata_valid,  0);
            check($sformatf("post-reset k%0d done", k),        done,         0);
            check($sformatf("post-reset k%0d burst_en", k),    mem_burst_en, 0);
            check($sformatf("post-reset k%0d req_ready", k),   req_ready,    1);
        end

        read_burst(16'h0100, 8'hA0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/burst_master.md
Name: burst_master

Overview:
- Initiator side of the burst SRAM path: accepts one burst request (base address, read/write), then drives BURST_LEN consecutive single-beat SRAM accesses at incrementing addresses.
- Write beats come from a valid/ready data stream. Read data returns on a valid-qualified output stream.
- Sits in front of the burst address generator and SRAM. It is the requester that those blocks serve.

Parameters:
- ADDR_WIDTH, 16, width of the memory address.
- DATA_WIDTH, 8, width of one data beat.
- BURST_LEN, 8, beats per burst; legal range 1..256.
- RD_LATENCY, 1, cycles from mem_rden high to valid mem_rd_data; legal range 1..4.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  asynchronous active-low reset.
- req_valid  input  1  burst request present.
- req_ready  output  1  block idle and able to accept a request.
- req_write  input  1  1 = write burst, 0 = read burst; sampled on accept.
- req_addr  input  ADDR_WIDTH  burst base address; sampled on accept.
- wdata_valid  input  1  write beat available.
- wdata_ready  output  1  write beat consumed this cycle.
- wdata  input  DATA_WIDTH  write beat data.
- rdata_valid  output  1  rdata holds a returned read beat.
- rdata  output  DATA_WIDTH  read beat data.
- done  output  1  one-cycle pulse when a burst has fully completed.
- mem_burst_en  output  1  high during every cycle of an active burst.
- mem_addr  output  ADDR_WIDTH  beat address.
- mem_wren  output  1  SRAM write strobe.
- mem_rden  output  1  SRAM read strobe.
- mem_wr_data  output  DATA_WIDTH  SRAM write data.
- mem_rd_data  input  DATA_WIDTH  SRAM read data.

Behaviour:
- Reset (rstn low, asynchronous): state IDLE.
  - req_ready=1.
  - All other outputs 0, including rdata, mem_addr and mem_wr_data.
  - Beat counter and read-latency pipeline cleared.
- Reset mid-burst: the burst is abandoned. No done pulse. No rdata_valid for reads still in flight.
- FSM states: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - req_ready=1.
  - On req_valid: latch base address and direction, clear beat count, go to WRITE or READ.
  - Memory strobes stay low on the accept cycle.
- WRITE:
  - mem_burst_en=1; mem_addr = base + beat (mod 2^ADDR_WIDTH).
  - wdata_ready = wdata_valid. The beat is combinationally forwarded: mem_wren = wdata_valid, mem_wr_data = wdata.
  - Beat increments only on a transfer. A cycle with wdata_valid low stalls with mem_wren=0 and the address held.
  - After the transfer of beat BURST_LEN-1, the next cycle is IDLE with done=1.
- READ:
  - mem_burst_en=1; mem_rden=1 every cycle; mem_addr = base + beat. No stalls.
  - After beat BURST_LEN-1: go to DRAIN.
- DRAIN:
  - mem_burst_en=0; strobes low.
  - Wait until the last read returns. done=1 in the cycle that the final rdata_valid is high; the next cycle is IDLE.
- Read return path:
  - mem_rden is delayed RD_LATENCY cycles through a shift register.
  - When the delayed bit is 1, capture mem_rd_data into rdata and assert rdata_valid on the following edge.
  - Total latency from mem_rden to rdata_valid is RD_LATENCY+1 cycles.
  - Exactly BURST_LEN rdata_valid pulses per read burst, in address order.
  - No backpressure on rdata.
- done:
  - Write burst: done is asserted in the first IDLE cycle after the final write beat.
  - Read burst: done coincides with the final rdata_valid.
- Address wrap-around: base + beat wraps modulo 2^ADDR_WIDTH. No error is signalled.
- BURST_LEN=1: single-beat burst with identical sequencing.
- req_valid while not in IDLE: ignored (req_ready=0). The request is not queued.
- wdata_valid outside WRITE: ignored, wdata_ready=0.
- Beat counter width: clog2(BURST_LEN+1) bits, saturating at BURST_LEN.

Test Plan:
- Write burst: req_addr=0x0100, req_write=1, wdata 0xA0..0xA7 back-to-back → mem_wren 8 consecutive cycles, mem_addr 0x0100..0x0107, one done pulse, req_ready=1 after.
- Read back, RD_LATENCY=1, SRAM model: read at 0x0100 → mem_rden 8 cycles; rdata_valid 8 cycles carrying 0xA0..0xA7 in order, first valid 2 cycles after first mem_rden; done with last beat.
- Write stalls: wdata_valid low on beats 2 and 5 → address holds during each stall, mem_wren=0 in stall cycles, final memory contents correct, burst takes 10 cycles.
- Wrap: req_addr=0xFFFE, write 4 beats with BURST_LEN=4 → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Busy rejection: pulse req_valid with req_addr=0x2000 during an active read → ignored, no second burst, req_ready=0 throughout.
- Reset mid-read: rstn low after beat 3 → all outputs 0 immediately, no done pulse, no further rdata_valid; a new request after reset completes normally.
